// File: rtl/wsi_pkg.sv
// rtl/wsi_pkg.sv - shared WSI command encoding, widths and burst-length helper
//
// Purpose: common types for the WSI burst source slice.
//   mCmdT   : WSI request command encoding.
//   stateT  : burst source sequencing states.
//   DATA/LEN/INFO/BE : WSI field widths.
//   pickLen : maps a random byte onto a burst length in 1..maxLen.
package wsi_pkg;

  localparam int DATA = 32;
  localparam int LEN  = 12;
  localparam int INFO = 8;
  localparam int BE   = 4;

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    WR   = 3'b001,
    RD   = 3'b010
  } mCmdT;

  typedef enum logic [1:0] {
    WAIT_PEER,
    GAP,
    LOAD,
    BURST
  } stateT;

  function automatic logic [LEN-1:0] pickLen(input logic [7:0] r, input int maxLen);
    return LEN'((int'(r) % maxLen) + 1);
  endfunction

endpackage

// File: rtl/wsi_burst_source_rng.sv
// rtl/wsi_burst_source_rng.sv - free-running Galois LFSR random source
//
// Purpose: pseudo-random word that advances on every clock.
// Ports:
//   clk   : clock.
//   reset : synchronous, active-high; reloads the seed.
//   value : current LFSR state.
module RandomNumberGenerator #(
  parameter int WIDTH = 32,
  parameter int SEED  = 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] value
);

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form.
  localparam logic [WIDTH-1:0] TAPS  = WIDTH'(32'h8020_0003);
  // An all-zero state would lock the LFSR, so a zero seed falls back to 1.
  localparam logic [WIDTH-1:0] START = (SEED == 0) ? WIDTH'(1) : WIDTH'(SEED);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= START;
    end else if (value[0]) begin
      value <= (value >> 1) ^ TAPS;
    end else begin
      value <= value >> 1;
    end
  end

endmodule

// File: rtl/wsi_burst_source.sv
// rtl/wsi_burst_source.sv - WSI write-burst traffic source with random length/gap
//
// Purpose: emits precise WSI write bursts separated by idle gaps. Length and
// gap are either fixed by parameter or drawn from the random source.
// Ports:
//   clk, reset         : clock, synchronous active-high reset.
//   enable             : permits a new burst to start (never truncates one).
//   wsi_SThreadBusy    : slave flow control; a word issues only when low.
//   wsi_SReset_n       : slave out of reset; low aborts the current burst.
//   wsi_M*             : registered WSI master request fields.
//   burst_count        : completed bursts, wraps at 16 bits.
module wsi_burst_source
  import wsi_pkg::*;
#(
  parameter int SEED      = 1,
  parameter int MAX_LEN   = 16,
  parameter int FIXED_LEN = 0,
  parameter int FIXED_GAP = -1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            wsi_SThreadBusy,
  input  logic            wsi_SReset_n,
  output logic [2:0]      wsi_MCmd,
  output logic            wsi_MReqLast,
  output logic            wsi_MBurstPrecise,
  output logic [LEN-1:0]  wsi_MBurstLength,
  output logic [DATA-1:0] wsi_MData,
  output logic [BE-1:0]   wsi_MByteEn,
  output logic [INFO-1:0] wsi_MReqInfo,
  output logic            wsi_MReset_n,
  output logic [15:0]     burst_count
);

  logic [31:0]    rngVal;
  logic           unusedRng;
  stateT          state;
  logic [2:0]     gapCnt;
  logic [2:0]     gapSeed;
  logic [LEN-1:0] burstLen;
  logic [LEN-1:0] loadLen;
  logic [7:0]     wordIdx;
  logic           lastWord;

  RandomNumberGenerator #(
    .WIDTH(32),
    .SEED (SEED)
  ) rng (
    .clk  (clk),
    .reset(reset),
    .value(rngVal)
  );

  assign unusedRng = ^{rngVal[31:16], rngVal[7], rngVal[3:0]};

  always_comb begin
    gapSeed = (FIXED_GAP < 0) ? rngVal[6:4] : 3'(FIXED_GAP);
    loadLen = (FIXED_LEN != 0) ? LEN'(FIXED_LEN) : pickLen(rngVal[15:8], MAX_LEN);
  end

  assign lastWord = ({4'b0000, wordIdx} == burstLen - 12'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= WAIT_PEER;
      gapCnt            <= '0;
      burstLen          <= '0;
      wordIdx           <= '0;
      wsi_MCmd          <= IDLE;
      wsi_MReqLast      <= 1'b0;
      wsi_MBurstPrecise <= 1'b0;
      wsi_MBurstLength  <= '0;
      wsi_MData         <= '0;
      wsi_MByteEn       <= '0;
      wsi_MReqInfo      <= '0;
      wsi_MReset_n      <= 1'b0;
      burst_count       <= '0;
    end else begin
      wsi_MReset_n      <= 1'b1;
      // Idle presentation unless a word is issued below.
      wsi_MCmd          <= IDLE;
      wsi_MReqLast      <= 1'b0;
      wsi_MBurstPrecise <= 1'b0;
      wsi_MBurstLength  <= '0;
      wsi_MData         <= '0;
      wsi_MByteEn       <= '0;
      wsi_MReqInfo      <= '0;

      if (!wsi_SReset_n) begin
        // Peer went away: drop the partial burst without counting it.
        state   <= WAIT_PEER;
        wordIdx <= '0;
      end else begin
        unique case (state)
          WAIT_PEER: begin
            if (wsi_MReset_n) begin
              state  <= GAP;
              gapCnt <= gapSeed;
            end
          end
          GAP: begin
            if (gapCnt != 3'd0) begin
              gapCnt <= gapCnt - 3'd1;
            end else if (enable) begin
              state <= LOAD;
            end
          end
          LOAD: begin
            burstLen <= loadLen;
            wordIdx  <= '0;
            state    <= BURST;
          end
          BURST: begin
            if (!wsi_SThreadBusy) begin
              wsi_MCmd          <= WR;
              wsi_MBurstPrecise <= 1'b1;
              wsi_MBurstLength  <= burstLen;
              wsi_MData         <= {burst_count, 8'h00, wordIdx};
              wsi_MByteEn       <= 4'hF;
              wsi_MReqInfo      <= burst_count[7:0];
              wordIdx           <= wordIdx + 8'd1;
              if (lastWord) begin
                wsi_MReqLast <= 1'b1;
                burst_count  <= burst_count + 16'd1;
                state        <= GAP;
                gapCnt       <= gapSeed;
              end
            end
          end
          default: state <= WAIT_PEER;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wsi_burst_source.sv
// tb/tb_wsi_burst_source.sv - directed bench for wsi_burst_source
`timescale 1ns/1ps
module tb_wsi_burst_source;
  import wsi_pkg::*;

  logic clk = 1'b0;
  logic reset, enable, busy, sResetN;

  logic [2:0]  aCmd, bCmd, cCmd;
  logic        aLast, bLast, cLast;
  logic        aPrecise, bPrecise, cPrecise;
  logic [11:0] aLen, bLen, cLen;
  logic [31:0] aData, bData, cData;
  logic [3:0]  aBe, bBe, cBe;
  logic [7:0]  aInfo, bInfo, cInfo;
  logic        aMResetN, bMResetN, cMResetN;
  logic [15:0] aCount, bCount, cCount;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wsi_burst_source #(.SEED(1), .MAX_LEN(16), .FIXED_LEN(4), .FIXED_GAP(2)) dutA (
    .clk(clk), .reset(reset), .enable(enable), .wsi_SThreadBusy(busy), .wsi_SReset_n(sResetN),
    .wsi_MCmd(aCmd), .wsi_MReqLast(aLast), .wsi_MBurstPrecise(aPrecise), .wsi_MBurstLength(aLen),
    .wsi_MData(aData), .wsi_MByteEn(aBe), .wsi_MReqInfo(aInfo), .wsi_MReset_n(aMResetN),
    .burst_count(aCount));

  wsi_burst_source #(.SEED(7), .MAX_LEN(16), .FIXED_LEN(1), .FIXED_GAP(0)) dutB (
    .clk(clk), .reset(reset), .enable(enable), .wsi_SThreadBusy(busy), .wsi_SReset_n(sResetN),
    .wsi_MCmd(bCmd), .wsi_MReqLast(bLast), .wsi_MBurstPrecise(bPrecise), .wsi_MBurstLength(bLen),
    .wsi_MData(bData), .wsi_MByteEn(bBe), .wsi_MReqInfo(bInfo), .wsi_MReset_n(bMResetN),
    .burst_count(bCount));

  wsi_burst_source #(.SEED(32'h1234_5678), .MAX_LEN(5), .FIXED_LEN(0), .FIXED_GAP(-1)) dutC (
    .clk(clk), .reset(reset), .enable(enable), .wsi_SThreadBusy(busy), .wsi_SReset_n(sResetN),
    .wsi_MCmd(cCmd), .wsi_MReqLast(cLast), .wsi_MBurstPrecise(cPrecise), .wsi_MBurstLength(cLen),
    .wsi_MData(cData), .wsi_MByteEn(cBe), .wsi_MReqInfo(cInfo), .wsi_MReset_n(cMResetN),
    .burst_count(cCount));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitWrA(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (aCmd !== 3'(WR) && n < budget);
  endtask

  task automatic checkIdleA(input string tag);
    check({tag, "_cmd"}, aCmd, IDLE);
    check({tag, "_last"}, aLast, 1'b0);
    check({tag, "_data"}, aData, 32'h0);
  endtask

  initial begin
    int n, wrSeen, bWords, badB, badC, cIdx, cBursts;
    logic [15:0] bModel, cModel;
    logic [11:0] cCurLen;
    logic [7:0]  lastInfo;
    logic        seen1, seen5;

    reset = 1'b1; enable = 1'b1; busy = 1'b0; sResetN = 1'b1;
    tick(); tick();
    check("rst_cmd", aCmd, IDLE);
    check("rst_mresetn", aMResetN, 1'b0);
    check("rst_count", aCount, 16'h0);
    check("rst_data", aData, 32'h0);
    check("rst_len", aLen, 12'h0);

    // Burst 0: four words, fixed gap of two.
    reset = 1'b0;
    tick();
    check("mresetn_rise", aMResetN, 1'b1);
    check("no_early_req", aCmd, IDLE);
    waitWrA(20, n);
    check("first_req_latency", n + 1, 7);
    check("b0_precise", aPrecise, 1'b1);
    check("b0_be", aBe, 4'hF);
    check("b0_info", aInfo, 8'h00);
    for (int w = 0; w < 4; w++) begin
      if (w > 0) tick();
      check("b0_cmd", aCmd, WR);
      check("b0_data", aData, 32'(w));
      check("b0_last", aLast, w == 3);
      check("b0_len", aLen, 12'd4);
    end
    check("b0_count", aCount, 16'd1);

    // Two gap cycles plus LOAD plus one cycle of issue latency stay idle.
    tick();
    checkIdleA("gap");
    waitWrA(20, n);
    check("gap_idle_cycles", n, 4);
    check("b1_w0_data", aData, 32'h0001_0000);
    check("b1_w0_info", aInfo, 8'h01);

    // Burst 1: slave busy for two word slots.
    busy = 1'b1;
    tick();
    checkIdleA("busy1");
    tick();
    checkIdleA("busy2");
    busy = 1'b0;
    tick();
    check("b1_w1_data", aData, 32'h0001_0001);
    tick();
    check("b1_w2_data", aData, 32'h0001_0002);
    check("b1_w2_last", aLast, 1'b0);
    tick();
    check("b1_w3_data", aData, 32'h0001_0003);
    check("b1_w3_last", aLast, 1'b1);
    check("b1_count", aCount, 16'd2);

    // Burst 2: peer reset after word 1, then restart from word 0.
    waitWrA(20, n);
    check("b2_w0_data", aData, 32'h0002_0000);
    tick();
    check("b2_w1_data", aData, 32'h0002_0001);
    sResetN = 1'b0;
    tick();
    checkIdleA("sreset1");
    check("sreset_count", aCount, 16'd2);
    tick();
    checkIdleA("sreset2");
    sResetN = 1'b1;
    waitWrA(20, n);
    check("restart_latency", n, 6);
    check("restart_w0_data", aData, 32'h0002_0000);
    check("restart_w0_last", aLast, 1'b0);
    tick(); tick(); tick();
    check("restart_w3_data", aData, 32'h0002_0003);
    check("restart_w3_last", aLast, 1'b1);
    check("restart_count", aCount, 16'd3);

    // Burst 3: enable dropped mid-burst still completes, then holds off.
    waitWrA(20, n);
    check("b3_w0_data", aData, 32'h0003_0000);
    enable = 1'b0;
    tick(); tick(); tick();
    check("b3_w3_data", aData, 32'h0003_0003);
    check("b3_w3_last", aLast, 1'b1);
    check("b3_count", aCount, 16'd4);
    wrSeen = 0;
    repeat (12) begin
      tick();
      if (aCmd === 3'(WR)) wrSeen++;
    end
    check("enable_hold", wrSeen, 0);
    enable = 1'b1;
    waitWrA(8, n);
    check("enable_resume_latency", n, 3);
    check("b4_w0_data", aData, 32'h0004_0000);
    tick();
    check("b4_w1_data", aData, 32'h0004_0001);

    // Reset in the middle of burst 4.
    reset = 1'b1;
    tick();
    check("midrst_cmd", aCmd, IDLE);
    check("midrst_last", aLast, 1'b0);
    check("midrst_data", aData, 32'h0);
    check("midrst_len", aLen, 12'h0);
    check("midrst_info", aInfo, 8'h0);
    check("midrst_be", aBe, 4'h0);
    check("midrst_precise", aPrecise, 1'b0);
    check("midrst_count", aCount, 16'h0);
    check("midrst_mresetn", aMResetN, 1'b0);
    reset = 1'b0;
    tick();
    check("midrst_mresetn_rise", aMResetN, 1'b1);
    check("midrst_cmd_after", aCmd, IDLE);

    // Single-word bursts until burst_count wraps; random-length source alongside.
    bModel = 16'h0; bWords = 0; badB = 0; lastInfo = 8'h0;
    cModel = 16'h0; cIdx = 0; cBursts = 0; badC = 0; cCurLen = 12'h0;
    seen1 = 1'b0; seen5 = 1'b0;
    for (int cyc = 0; cyc < 200000 && bWords < 65536; cyc++) begin
      tick();
      if (bCmd === 3'(WR)) begin
        if (bData !== {bModel, 16'h0} || bInfo !== bModel[7:0] || bLast !== 1'b1 ||
            bLen !== 12'd1 || bCount !== bModel + 16'd1)
          badB++;
        lastInfo = bInfo;
        bModel = bModel + 16'd1;
        bWords++;
      end
      if (cCmd === 3'(WR)) begin
        if (cIdx == 0) cCurLen = cLen;
        if (cLen < 12'd1 || cLen > 12'd5 || cLen !== cCurLen ||
            cData !== {cModel, 16'(cIdx)} || cLast !== (cIdx == int'(cLen) - 1))
          badC++;
        if (cLen == 12'd1) seen1 = 1'b1;
        if (cLen == 12'd5) seen5 = 1'b1;
        if (cLast) begin
          cModel = cModel + 16'd1;
          cIdx = 0;
          cBursts++;
        end else begin
          cIdx++;
        end
      end else if (cCmd !== 3'(IDLE)) begin
        badC++;
      end
    end
    check("wrap_words", bWords, 65536);
    check("wrap_count", bCount, 16'h0);
    check("wrap_last_info", lastInfo, 8'hFF);
    check("wrap_word_errors", badB, 0);
    check("rand_errors", badC, 0);
    check("rand_burst_volume", cBursts > 1000, 1'b1);
    check("rand_len1_seen", seen1, 1'b1);
    check("rand_len_max_seen", seen5, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
